// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, load/store port and the shared memory port.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_ack;
    logic [DATA_WIDTH-1:0] i_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [STRB_WIDTH-1:0] d_wstrb;
    logic                  d_ack;
    logic [DATA_WIDTH-1:0] d_rdata;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [STRB_WIDTH-1:0] mem_wstrb;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  mem_ready, mem_rdata,
        output i_ack, i_rdata, d_ack, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output i_req, i_addr,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        output mem_ready, mem_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter in front of a single-port memory.
// Define MEM_ARBITER_ROUND_ROBIN_EN to alternate simultaneous requests; default is data-over-fetch priority.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    mem_arbiter_if.slave    bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT_I = 2'd1;
    localparam logic [1:0] GRANT_D = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]            state_reg;
    logic                  i_ack_reg;
    logic                  d_ack_reg;
    logic [DATA_WIDTH-1:0] i_rdata_reg;
    logic [DATA_WIDTH-1:0] d_rdata_reg;
    logic                  mem_req_reg;
    logic                  mem_we_reg;
    logic [ADDR_WIDTH-1:0] mem_addr_reg;
    logic [DATA_WIDTH-1:0] mem_wdata_reg;
    logic [STRB_WIDTH-1:0] mem_wstrb_reg;
    logic                  pick_d;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    // 1 = load/store was granted last, 0 = fetch was granted last
    logic last_d_reg;

    always_comb begin
        pick_d = bus.d_req && (!bus.i_req || !last_d_reg);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_d_reg <= 1'b0;
        end else if (state_reg == IDLE && (bus.i_req || bus.d_req)) begin
            last_d_reg <= pick_d;
        end
    end
`else
    always_comb begin
        pick_d = bus.d_req;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            i_ack_reg     <= 1'b0;
            d_ack_reg     <= 1'b0;
            i_rdata_reg   <= '0;
            d_rdata_reg   <= '0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_wstrb_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.i_req || bus.d_req) begin
                        mem_req_reg <= 1'b1;
                        if (pick_d) begin
                            state_reg     <= GRANT_D;
                            mem_we_reg    <= bus.d_we;
                            mem_addr_reg  <= bus.d_addr;
                            mem_wdata_reg <= bus.d_wdata;
                            mem_wstrb_reg <= bus.d_wstrb;
                        end else begin
                            state_reg     <= GRANT_I;
                            mem_we_reg    <= 1'b0;
                            mem_addr_reg  <= bus.i_addr;
                            mem_wdata_reg <= '0;
                            mem_wstrb_reg <= '0;
                        end
                    end
                end
                GRANT_I, GRANT_D: begin
                    // mem_req is always high here, so mem_ready is only honoured mid-request
                    if (bus.mem_ready) begin
                        state_reg   <= DONE;
                        mem_req_reg <= 1'b0;
                        if (state_reg == GRANT_I) begin
                            i_rdata_reg <= bus.mem_rdata;
                            i_ack_reg   <= 1'b1;
                        end else begin
                            d_rdata_reg <= bus.mem_rdata;
                            d_ack_reg   <= 1'b1;
                        end
                    end
                end
                default: begin
                    // DONE ignores requests so a req still high during its ack is not re-granted
                    state_reg <= IDLE;
                    i_ack_reg <= 1'b0;
                    d_ack_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.i_ack     = i_ack_reg;
    assign bus.i_rdata   = i_rdata_reg;
    assign bus.d_ack     = d_ack_reg;
    assign bus.d_rdata   = d_rdata_reg;
    assign bus.mem_req   = mem_req_reg;
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.mem_wstrb = mem_wstrb_reg;
endmodule
